// File: rtl/acc_sched_pkg.sv
// acc_sched_pkg: shared types and constants for the accelerator job scheduler.
package acc_sched_pkg;

    localparam int ACC_DATA_W = 32;
    localparam int ACC_LANE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_FETCH = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

endpackage : acc_sched_pkg

// File: rtl/accel_count_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or
// after the pointer, searching upwards with wrap-around.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
    output logic                       any_o
);

    logic found;

    // Walk the request vector starting at the pointer; first hit wins.
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        any_o     = |req_i;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = (int'(ptr_i) + i) % NUM_REQ;
            if (!found && req_i[idx]) begin
                found     = 1'b1;
                gnt_idx_o = ($clog2(NUM_REQ))'(idx);
            end
        end
        if (found) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

endmodule : rr_arbiter

// File: rtl/accel_count_sched.sv
// accel_count_sched: round-robin scheduler feeding one even-lane counter
// accelerator. Each job streams len words, one start per word, and reports
// the accelerator's cumulative-count delta. Optional watchdog on the done
// wait is enabled by defining ACC_SCHED_TIMEOUT_EN.
module accel_count_sched
    import acc_sched_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int LEN_W          = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk_i,
    input  logic                          arst_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*LEN_W-1:0]      len_i,
    input  logic [NUM_REQ*ACC_DATA_W-1:0] wdata_i,
    input  logic [NUM_REQ-1:0]            wvalid_i,
    output logic [NUM_REQ-1:0]            wready_o,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id_o,
    output logic [ACC_DATA_W-1:0]         rsp_count_o,
    output logic                          rsp_err_o,
    output logic                          acc_start_o,
    output logic [ACC_DATA_W-1:0]         acc_data_o,
    input  logic [ACC_DATA_W-1:0]         acc_data_i,
    input  logic                          acc_done_i
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_e                 state_q, state_d;
    logic [ID_W-1:0]        grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]     grant_oh_q, grant_oh_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [LEN_W-1:0]       remaining_q, remaining_d;
    logic [ACC_DATA_W-1:0]  base_q, base_d;
    logic [ACC_DATA_W-1:0]  acc_data_q, acc_data_d;
    logic [ACC_DATA_W-1:0]  rsp_count_q, rsp_count_d;

    logic [NUM_REQ-1:0]     arb_gnt;
    logic [ID_W-1:0]        arb_idx;
    logic                   arb_any;

    logic [LEN_W-1:0]       len_sel;
    logic [ACC_DATA_W-1:0]  wdata_sel;
    logic [ID_W-1:0]        next_ptr;

`ifdef ACC_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   rsp_err_q, rsp_err_d;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i     (req_i),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .any_o     (arb_any)
    );

    assign len_sel     = len_i[grant_id_q*LEN_W +: LEN_W];
    assign wdata_sel   = wdata_i[grant_id_q*ACC_DATA_W +: ACC_DATA_W];
    assign next_ptr    = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
    assign rsp_id_o    = grant_id_q;
    assign rsp_count_o = rsp_count_q;
    assign acc_data_o  = acc_data_q;
`ifdef ACC_SCHED_TIMEOUT_EN
    assign rsp_err_o   = rsp_err_q;
`else
    assign rsp_err_o   = 1'b0;
`endif

    // Next-state and output decode for the job sequencer.
    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        grant_oh_d  = grant_oh_q;
        rr_ptr_d    = rr_ptr_q;
        remaining_d = remaining_q;
        base_d      = base_q;
        acc_data_d  = acc_data_q;
        rsp_count_d = rsp_count_q;
`ifdef ACC_SCHED_TIMEOUT_EN
        wd_d        = wd_q;
        rsp_err_d   = rsp_err_q;
`endif
        wready_o    = '0;
        acc_start_o = 1'b0;
        rsp_valid_o = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    grant_id_d = arb_idx;
                    grant_oh_d = arb_gnt;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                remaining_d = len_sel;
                base_d      = acc_data_i;
                rr_ptr_d    = next_ptr;
`ifdef ACC_SCHED_TIMEOUT_EN
                rsp_err_d   = 1'b0;
`endif
                if (len_sel == '0) begin
                    rsp_count_d = '0;
                    state_d     = ST_RESP;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                wready_o = grant_oh_q;
                if (wvalid_i[grant_id_q]) begin
                    acc_data_d  = wdata_sel;
                    remaining_d = remaining_q - 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                acc_start_o = 1'b1;
`ifdef ACC_SCHED_TIMEOUT_EN
                wd_d        = '0;
`endif
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (acc_done_i) begin
                    if (remaining_q != '0) begin
                        state_d = ST_FETCH;
                    end else begin
                        // Modulo subtraction keeps the delta right across counter wrap.
                        rsp_count_d = acc_data_i - base_q;
                        state_d     = ST_RESP;
                    end
                end
`ifdef ACC_SCHED_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_count_d = acc_data_i - base_q;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any job in flight.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= ST_IDLE;
            grant_id_q  <= '0;
            grant_oh_q  <= '0;
            rr_ptr_q    <= '0;
            remaining_q <= '0;
            base_q      <= '0;
            acc_data_q  <= '0;
            rsp_count_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            grant_oh_q  <= grant_oh_d;
            rr_ptr_q    <= rr_ptr_d;
            remaining_q <= remaining_d;
            base_q      <= base_d;
            acc_data_q  <= acc_data_d;
            rsp_count_q <= rsp_count_d;
        end
    end

`ifdef ACC_SCHED_TIMEOUT_EN
    // Watchdog counter and sticky error flag for the current job.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wd_q      <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            rsp_err_q <= rsp_err_d;
        end
    end
`endif

endmodule : accel_count_sched

// File: tb/tb_accel_count_sched.sv
// tb_accel_count_sched: randomized self-checking bench. A behavioural
// accelerator counts even byte lanes; a job-level model predicts the
// round-robin response order and each job's count.
module tb_accel_count_sched;

    localparam int N  = 3;
    localparam int LW = 8;
    localparam int TO = 16;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            arst_i;
    logic [N-1:0]    req_i;
    logic [N*LW-1:0] len_i;
    logic [N*32-1:0] wdata_i;
    logic [N-1:0]    wvalid_i;
    logic [N-1:0]    wready_o;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [IW-1:0]   rsp_id_o;
    logic [31:0]     rsp_count_o;
    logic            rsp_err_o;
    logic            acc_start_o;
    logic [31:0]     acc_data_o;
    logic [31:0]     acc_data_i;
    logic            acc_done_i;

    accel_count_sched #(.NUM_REQ(N), .LEN_W(LW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .arst_i(arst_i), .req_i(req_i), .len_i(len_i),
        .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_count_o(rsp_count_o), .rsp_err_o(rsp_err_o), .acc_start_o(acc_start_o),
        .acc_data_o(acc_data_o), .acc_data_i(acc_data_i), .acc_done_i(acc_done_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Spec-level count: number of 8-bit lanes whose value is even.
    function automatic int even_lanes(input logic [31:0] w);
        int n = 0;
        for (int b = 0; b < 4; b++) if (w[8*b] == 1'b0) n++;
        return n;
    endfunction

    // Per-requester word streams, job lengths and expected job counts.
    logic [31:0] wq [N][$];
    int          jl [N][$];
    int          ec [N][$];
    logic [31:0] stage [$];
    logic [N-1:0] hs = '0;
    int  starts = 0, wr_cycles = 0, onehot_viol = 0, hold_viol = 0;
    int  p = 0;
    bit  stall = 0;
    int  cd = 0, pend = 0;

    // Word feeder: pop on completed handshake, then offer the next word with random valid.
    always @(negedge clk) begin
        if (arst_i) begin
            hs = '0;
            wvalid_i = '0;
        end else begin
            for (int r = 0; r < N; r++) if (hs[r] && wq[r].size() > 0) void'(wq[r].pop_front());
            for (int r = 0; r < N; r++) begin
                if (wq[r].size() > 0) begin
                    wdata_i[r*32 +: 32] = wq[r][0];
                    wvalid_i[r] = ($urandom_range(3) != 0);
                end else begin
                    wvalid_i[r] = 1'b0;
                end
            end
            hs = wvalid_i & wready_o;
            if ($countones(wready_o) > 1) onehot_viol++;
            if (wready_o != '0) wr_cycles++;
        end
    end

    // Accelerator model: cumulative even-lane counter with 1..4 cycle done latency.
    // A stray done during the start cycle must be ignored by the scheduler.
    always @(negedge clk) begin
        if (arst_i) begin
            acc_data_i = 32'hFFFF_FFF8;
            acc_done_i = 1'b0;
            cd = 0;
        end else begin
            acc_done_i = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    acc_data_i = acc_data_i + 32'(pend);
                    acc_done_i = 1'b1;
                end
            end
            if (acc_start_o) begin
                starts++;
                pend = even_lanes(acc_data_o);
                cd = stall ? 0 : $urandom_range(4, 1);
                acc_done_i = 1'($urandom_range(1));
            end
        end
    end

    task automatic add_job(input int r);
        int cnt = 0;
        jl[r].push_back(stage.size());
        foreach (stage[i]) begin
            wq[r].push_back(stage[i]);
            cnt += even_lanes(stage[i]);
        end
        ec[r].push_back(cnt);
        stage.delete();
    endtask

    task automatic accept_and_advance(input int id);
        rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0;
        void'(jl[id].pop_front());
        if (jl[id].size() == 0) req_i[id] = 1'b0;
        else len_i[id*LW +: LW] = LW'(jl[id][0]);
    endtask

    task automatic wait_rsp(input int eid, input int ecnt, input int hold);
        int n = 0;
        logic [IW-1:0] id0;
        logic [31:0] c0;
        @(negedge clk);
        while (!rsp_valid_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid_o) begin
            check("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        check("rsp_id", 32'(rsp_id_o), 32'(eid));
        check("rsp_count", rsp_count_o, 32'(ecnt));
        check("rsp_err", 32'(rsp_err_o), 32'd0);
        id0 = rsp_id_o;
        c0  = rsp_count_o;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!rsp_valid_o || rsp_id_o != id0 || rsp_count_o != c0 ||
                wready_o != '0 || acc_start_o) hold_viol++;
        end
        accept_and_advance(eid);
    endtask

    // Raise all queued jobs at once and expect round-robin service order.
    task automatic run_batch(input int hold);
        int left[N];
        int njobs = 0, words = 0, s0, r, c;
        s0 = starts;
        for (int k = 0; k < N; k++) begin
            left[k] = jl[k].size();
            njobs += left[k];
            foreach (jl[k][j]) words += jl[k][j];
            if (left[k] > 0) len_i[k*LW +: LW] = LW'(jl[k][0]);
        end
        for (int k = 0; k < N; k++) req_i[k] = (left[k] > 0);
        for (int j = 0; j < njobs; j++) begin
            r = -1;
            for (int k = 0; k < N; k++) begin
                c = (p + k) % N;
                if (r < 0 && left[c] > 0) r = c;
            end
            left[r]--;
            p = (r + 1) % N;
            wait_rsp(r, ec[r].pop_front(), (hold < 0) ? $urandom_range(3) : hold);
        end
        check("start_pulses", 32'(starts - s0), 32'(words));
        check("wready_onehot", 32'(onehot_viol), 32'd0);
        check("rsp_hold_stable", 32'(hold_viol), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, 32'({wready_o, rsp_valid_o, rsp_id_o, rsp_err_o, acc_start_o}), 32'd0);
        check({tag, "_count"}, rsp_count_o, 32'd0);
        check({tag, "_accdata"}, acc_data_o, 32'd0);
    endtask

    initial begin
        int wr0, n, cyc;
        bit seen;
        arst_i = 1'b1;
        req_i = '0; len_i = '0; wdata_i = '0; wvalid_i = '0; rsp_ready_i = 1'b0;
        acc_data_i = 32'hFFFF_FFF8; acc_done_i = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        arst_i = 1'b0;

        // Two requesters raised together after reset: id0 first, then id1.
        stage.push_back(32'h0204_0608); add_job(0);
        stage.push_back(32'h0103_0507); add_job(1);
        run_batch(0);

        // Single three-word job.
        stage.push_back(32'h0102_0304); stage.push_back(32'h0506_0708);
        stage.push_back(32'h090A_0B0C); add_job(0);
        run_batch(1);

        // Second job reports only its own delta.
        stage.push_back(32'h0102_0304); stage.push_back(32'h0102_0304); add_job(1);
        run_batch(0);

        // Zero-length job: no words, no starts.
        wr0 = wr_cycles;
        add_job(0);
        run_batch(0);
        check("zero_len_wready", 32'(wr_cycles - wr0), 32'd0);

        // Response backpressure while another requester waits.
        stage.push_back(32'hAABB_CCDD); add_job(0);
        stage.push_back(32'h1122_3344); add_job(1);
        run_batch(5);

        // A requester still asserting after its response yields to the others.
        stage.push_back(32'h0000_0001); add_job(0);
        stage.push_back(32'h0202_0202); add_job(0);
        stage.push_back(32'h0303_0303); add_job(1);
        stage.push_back(32'h0404_0505); add_job(2);
        run_batch(-1);

        // Random batches.
        for (int b = 0; b < 25; b++) begin
            int any = 0;
            for (int r = 0; r < N; r++) begin
                int nj = $urandom_range(2);
                for (int j = 0; j < nj; j++) begin
                    int len = $urandom_range(4);
                    for (int w = 0; w < len; w++) stage.push_back($urandom);
                    add_job(r);
                    any++;
                end
            end
            if (any == 0) begin
                stage.push_back($urandom);
                add_job($urandom_range(N - 1));
            end
            run_batch(-1);
        end

`ifdef ACC_SCHED_TIMEOUT_EN
        // Watchdog: no done ever arrives; error response TO cycles into WAIT.
        stall = 1;
        stage.push_back(32'h0); stage.push_back(32'h0); add_job(p);
        void'(ec[p].pop_front());
        req_i[p] = 1'b1; len_i[p*LW +: LW] = LW'(2);
        n = 0;
        do begin @(negedge clk); n++; end while (!acc_start_o && n < 200);
        cyc = 0;
        while (!rsp_valid_o && cyc < 200) begin @(negedge clk); cyc++; end
        check("timeout_cycles", 32'(cyc), 32'(TO + 1));
        check("timeout_err", 32'(rsp_err_o), 32'd1);
        check("timeout_count", rsp_count_o, 32'd0);
        check("timeout_id", 32'(rsp_id_o), 32'(p));
        accept_and_advance(p);
        req_i[p] = 1'b0;
        wq[p].delete(); jl[p].delete(); ec[p].delete();
        p = (p + 1) % N;
        stall = 0;
`endif

        // Reset in WAIT aborts the job silently.
        stall = 1;
        req_i[0] = 1'b1; len_i[0 +: LW] = LW'(3);
        wq[0].push_back(32'h1); wq[0].push_back(32'h2); wq[0].push_back(32'h3);
        n = 0;
        do begin @(negedge clk); n++; end while (!acc_start_o && n < 200);
        check("pre_reset_start", 32'(acc_start_o), 32'd1);
        @(posedge clk);
        #1;
        arst_i = 1'b1;
        req_i = '0;
        for (int r = 0; r < N; r++) begin wq[r].delete(); jl[r].delete(); ec[r].delete(); end
        #1;
        check_outputs_zero("midjob_reset");
        @(negedge clk);
        #1;
        arst_i = 1'b0;
        stall = 0;
        p = 0;
        seen = 0;
        repeat (20) begin @(negedge clk); if (rsp_valid_o || wready_o != '0) seen = 1; end
        check("no_rsp_after_reset", 32'(seen), 32'd0);

        // Normal operation resumes with the pointer back at zero.
        stage.push_back(32'h0102_0304); stage.push_back(32'h0606_0606); add_job(1);
        stage.push_back(32'h0808_0101); add_job(2);
        run_batch(-1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_accel_count_sched
